// File: rtl/montinvp2_pkg.sv
// montinvp2_pkg -- shared definitions for the Kaliski phase-2 correction stage.
//   state_t : FSM encoding (ST_IDLE, ST_RUN)
//   dir_t   : step direction (DIR_DBL = modular doubling, DIR_HALF = modular halving)
//   DEF_*   : default WIDTH / CWID / MEXP for the ECC core.
package montinvp2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    DIR_DBL  = 1'b0,
    DIR_HALF = 1'b1
  } dir_t;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_CWID  = 10;
  localparam int DEF_MEXP  = 256;

endpackage

// File: rtl/montinv_step.sv
// montinv_step -- combinational single step of the phase-2 loop.
//   r   in  WIDTH : current value, expected in [0, p)
//   p   in  WIDTH : odd modulus
//   dir in  dir_t : DIR_HALF -> r/2 mod p, DIR_DBL -> 2r mod p
//   res out WIDTH : stepped value, again in [0, p)
module montinv_step
  import montinvp2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] p,
  input  dir_t             dir,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH:0] sum_w;   // r + p, one extra bit so the carry survives the shift
  logic [WIDTH:0] dbl_w;   // 2r, one extra bit for the same reason
  logic [WIDTH:0] half_w;
  logic [WIDTH:0] red_w;
  logic [WIDTH:0] res_w;
  logic           unused_msb;

  assign sum_w = {1'b0, r} + {1'b0, p};
  assign dbl_w = {r, 1'b0};

  // Odd r: adding the odd modulus makes the value even, so halving is exact.
  assign half_w = r[0] ? (sum_w >> 1) : ({1'b0, r} >> 1);
  // r < p implies 2r < 2p, so a single conditional subtraction is enough.
  assign red_w  = (dbl_w >= {1'b0, p}) ? (dbl_w - {1'b0, p}) : dbl_w;

  assign res_w      = (dir == DIR_HALF) ? half_w : red_w;
  assign res        = res_w[WIDTH-1:0];
  // Both results are below p, so the top bit is always zero.
  assign unused_msb = res_w[WIDTH];

endmodule

// File: rtl/montinvp2.sv
// montinvp2 -- phase-2 correction of the Kaliski Montgomery inverse.
// Converts r = a^-1 * 2^k mod p into a^-1 * 2^MEXP mod p by |k - MEXP|
// modular halvings (k > MEXP) or doublings (k <= MEXP), one per cycle.
//   clk, rst : clock, synchronous active-high reset
//   mode     : (only with MONTINVP2_MODESEL_EN) 1 = target MEXP, 0 = target 0
//   ainv     : almost-inverse from phase 1, range [0, p]
//   exp      : exponent k from phase 1
//   mod      : odd modulus p
//   en       : start pulse, samples ainv/exp/mod(/mode); restarts a running op
//   minv     : corrected inverse, held until the next en
//   vld      : one-cycle pulse when minv is final
//   busy     : high while the correction loop runs
// Build option: define MONTINVP2_MODESEL_EN to add the mode input.
module montinvp2
  import montinvp2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CWID  = DEF_CWID,
  parameter int MEXP  = DEF_MEXP
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MONTINVP2_MODESEL_EN
  input  logic             mode,
`endif
  input  logic [WIDTH-1:0] ainv,
  input  logic [CWID-1:0]  exp,
  input  logic [WIDTH-1:0] mod,
  input  logic             en,
  output logic [WIDTH-1:0] minv,
  output logic             vld,
  output logic             busy
);

  localparam logic [CWID-1:0] MEXP_C = CWID'(MEXP);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CWID-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             vld_q, vld_d;

  logic [CWID-1:0]  target;
  logic [CWID-1:0]  n_load;
  dir_t             dir_load;
  logic [WIDTH-1:0] r_load;
  logic [WIDTH-1:0] r_step;

`ifdef MONTINVP2_MODESEL_EN
  assign target = mode ? MEXP_C : '0;
`else
  assign target = MEXP_C;
`endif

  // Subtract in the direction that cannot wrap.
  assign dir_load = (exp > target) ? DIR_HALF : DIR_DBL;
  assign n_load   = (exp > target) ? (exp - target) : (target - exp);
  // Phase 1 may hand over r == p; fold it into [0, p).
  assign r_load   = (ainv >= mod) ? (ainv - mod) : ainv;

  montinv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r  (r_q),
    .p  (p_q),
    .dir(dir_q),
    .res(r_step)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    r_d     = r_q;
    vld_d   = 1'b0;
    if (en) begin
      p_d   = mod;
      r_d   = r_load;
      dir_d = dir_load;
      cnt_d = n_load;
      if (n_load == '0) begin
        state_d = ST_IDLE;
        vld_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      r_d   = r_step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CWID'(1)) begin
        state_d = ST_IDLE;
        vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_DBL;
      cnt_q   <= '0;
      p_q     <= '0;
      r_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      r_q     <= r_d;
      vld_q   <= vld_d;
    end
  end

  assign minv = r_q;
  assign vld  = vld_q;
  assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_montinvp2.sv
// tb_montinvp2 -- directed self-checking bench for montinvp2 (WIDTH=8, MEXP=8).
module tb_montinvp2;

  localparam int WIDTH = 8;
  localparam int CWID  = 10;
  localparam int MEXP  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] ainv_i = '0;
  logic [CWID-1:0]  exp_i = '0;
  logic [WIDTH-1:0] mod_i = '0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] minv;
  logic             vld;
  logic             busy;
`ifdef MONTINVP2_MODESEL_EN
  logic             mode_i = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  montinvp2 #(
    .WIDTH(WIDTH),
    .CWID (CWID),
    .MEXP (MEXP)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef MONTINVP2_MODESEL_EN
    .mode(mode_i),
`endif
    .ainv(ainv_i),
    .exp (exp_i),
    .mod (mod_i),
    .en  (en),
    .minv(minv),
    .vld (vld),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one en cycle; returns just after the en edge.
  task automatic start(input int a, input int e, input int m);
    tick();
    en     = 1'b1;
    ainv_i = WIDTH'(a);
    exp_i  = CWID'(e);
    mod_i  = WIDTH'(m);
    tick();
    en     = 1'b0;
    // Non-en inputs must be ignored from here on.
    ainv_i = WIDTH'($urandom);
    exp_i  = CWID'($urandom);
    mod_i  = WIDTH'($urandom);
  endtask

  // Start an operation and check result, latency (edges after en) and busy length.
  task automatic run_op(input string tag, input int a, input int e, input int m,
                        input int exp_minv, input int exp_n);
    int idx;
    int busy_cnt;
    bit seen;
    start(a, e, m);
    idx      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (idx < 40) begin
      if (vld) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      tick();
      idx++;
    end
    chk({tag, " vld_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      $display("op %s: ainv=%0d exp=%0d p=%0d -> minv=%0d after %0d steps", tag, a, e, m, minv, idx);
      chk({tag, " minv"}, 32'(minv), 32'(exp_minv));
      chk({tag, " latency"}, 32'(idx), 32'(exp_n));
      chk({tag, " busy_len"}, 32'(busy_cnt), 32'(exp_n));
      chk({tag, " busy_with_vld"}, 32'(busy), 32'd0);
      tick();
      chk({tag, " vld_pulse"}, 32'(vld), 32'd0);
      chk({tag, " minv_held"}, 32'(minv), 32'(exp_minv));
    end
  endtask

  initial begin
    int vld_hits;
    tick();
    tick();
    rst = 1'b0;
    chk("reset minv", 32'(minv), 32'd0);
    chk("reset vld", 32'(vld), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);

    run_op("half_even", 12, 10, 13, 3, 2);
    run_op("half_odd", 11, 11, 13, 3, 3);
    run_op("double", 4, 6, 13, 3, 2);
    run_op("no_step", 3, 8, 13, 3, 0);
    run_op("r_eq_p", 13, 8, 13, 0, 0);
    run_op("ovf_half", 249, 9, 251, 250, 1);
    run_op("ovf_double", 200, 7, 251, 149, 1);

    // Reset in the middle of a 3-step run.
    start(11, 11, 13);
    chk("rst_abort busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort minv", 32'(minv), 32'd0);
    chk("rst_abort busy", 32'(busy), 32'd0);
    chk("rst_abort vld", 32'(vld), 32'd0);
    vld_hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vld) vld_hits++;
    end
    chk("rst_abort no_vld", 32'(vld_hits), 32'd0);
    $display("op rst_abort: minv=%0d busy=%0d", minv, busy);

    // en again in the middle of a run: the first operation is discarded.
    start(11, 11, 13);
    chk("en_abort vld_early", 32'(vld), 32'd0);
    run_op("en_abort", 4, 6, 13, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/montinvp2.md
Name: montinvp2

Overview:
- Phase-2 correction stage for the Kaliski Montgomery inverse.
- Consumes the almost-inverse r = a^-1 * 2^k mod p and exponent k from the phase-1 unit.
- Produces the Montgomery inverse a^-1 * 2^MEXP mod p by repeated modular halving (k > MEXP) or modular doubling (k < MEXP).
- Sits directly downstream of phase 1 in the ECC core inversion path.

Parameters:
- WIDTH, 256, operand and modulus width in bits.
- CWID, 10, exponent and counter width.
- MEXP, 256, target Montgomery exponent (R = 2^MEXP); must be < 2^CWID.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- ainv  input  WIDTH  almost-inverse from phase 1; range [0, p].
- exp  input  CWID  exponent k from phase 1.
- mod  input  WIDTH  odd modulus p, p < 2^WIDTH.
- en  input  1  start pulse; samples ainv, exp and mod.
- minv  output  WIDTH  corrected inverse; held until the next en.
- vld  output  1  one-cycle pulse when minv is final.
- busy  output  1  high while the correction loop runs.

Behaviour:
- Reset values: minv=0, vld=0, busy=0, state=IDLE, cnt=0, dir=0, p=0.
- States: IDLE and RUN.
- en (any state, including RUN) restarts the operation; this is the only abort.
  - Latch p <= mod.
  - Load r <= ainv, or ainv - p when ainv >= p (phase-1 output r=p maps to 0).
  - N = |exp - MEXP|; dir = 1 (halve) when exp > MEXP, 0 (double) otherwise.
  - N == 0: vld <= 1, state stays IDLE, busy=0.
  - N != 0: cnt <= N, state <= RUN, busy <= 1.
- RUN step, one per cycle:
  - Halve: r even -> r>>1; r odd -> (r+p)>>1, with the sum computed at WIDTH+1 bits.
  - Double: t = {r,1'b0} at WIDTH+1 bits; r <= (t >= p) ? t-p : t.
  - cnt <= cnt-1.
  - When cnt == 1: vld <= 1, busy <= 0, state <= IDLE on the same edge.
- Latency: vld high in cycle E+N+1, where the en edge is E. Throughput is one operation per N+1 cycles.
- vld is a single-cycle pulse and is never asserted in the same cycle as busy.
- minv = r, always below p once vld has fired.
- Inputs other than en are ignored outside the en cycle.
- rst mid-RUN: everything returns to reset values next cycle; no vld.
- exp and MEXP are compared as unsigned CWID values; the subtraction never wraps.

Optional Feature:
- Macro: MONTINVP2_MODESEL_EN.
- Defined:
  - Adds input port "mode" (1 bit), sampled with en.
  - mode=1: target exponent MEXP.
  - mode=0: target exponent 0, giving the plain inverse a^-1 mod p with N = exp, always halving.
- Undefined: no mode port; target is always MEXP.

Decomposition:
- Shared package: state encoding (IDLE, RUN), direction encoding, default WIDTH/CWID/MEXP constants.
- One sub-module, montinv_step: combinational modular half/double of a WIDTH-bit value mod p, selected by dir, with internal WIDTH+1-bit adder/comparator.
- The top level holds the FSM, counter and registers.

Test Plan (WIDTH=8, MEXP=8, p=13 unless stated; a=3, a^-1=9, expected minv=3):
- ainv=12, exp=10 -> two even halvings 12->6->3; minv=3, vld pulses 3 cycles after en, busy high for 2 cycles.
- ainv=11, exp=11 -> odd path (11+13)/2=12, then 6, then 3; minv=3, vld at E+4.
- ainv=4, exp=6 -> doublings 4->8->16-13=3; minv=3, vld at E+3.
- ainv=3, exp=8 -> no steps; minv=3, vld at E+1, busy never set. Separately, ainv=13, exp=8 -> minv=0.
- Width overflow, p=251:
  - ainv=249, exp=9 -> (249+251)>>1 = 250.
  - ainv=200, exp=7 -> 400-251 = 149.
- Abort cases, p=13, ainv=11, exp=11:
  - rst asserted mid-RUN -> minv=0, busy=0, no vld.
  - en re-asserted mid-RUN with ainv=4, exp=6 -> earlier operation discarded; minv=3 at E'+3.
